serial_subtractor: RTL and testbench

// - Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// - Complements the combinational full_adder: it computes the inverse arithmetic

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the step needs a borrow.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit per clock.
// Latency WIDTH+1 cycles incl. accept; start is ignored while busy, accepted in IDLE or DONE.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             bin_q;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bo_bit;
    logic             load;
    logic             step;
    logic             last;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bo_bit)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result bits enter at the MSB so after WIDTH steps the LSB has reached bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bin_q      <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d_bit, res_sr[WIDTH-1:1]};
            bin_q  <= bo_bit;
            cnt    <= cnt + CW'(1);
            if (last) begin
                diff       <= {d_bit, res_sr[WIDTH-1:1]};
                borrow_out <= bo_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed cases, random ops vs. arithmetic model, back-to-back, WIDTH=4 exhaustive.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bo8;
    logic [7:0] diff8;
    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bo4;
    logic [3:0] diff4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one 8-bit op and wait (bounded) for done; lat counts edges from the accepting edge.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                       output logic [7:0] rd, output logic rbo,
                       output int lat, output int bcnt, output logic [7:0] early);
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        early = diff8;
        lat = 1; bcnt = 0;
        while (!done8 && lat < 30) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
        rd = diff8; rbo = bo8;
    endtask

    initial begin
        logic [7:0] rd, early;
        logic       rbo;
        int         lat, bcnt, cyc, ndone, last_done, seen;
        logic [7:0] ea, eb;
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [4:0] ta4, tb4;

        reset = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        #1;
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_diff", 32'(diff8), 0);
        chk("rst_borrow", 32'(bo8), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 200 - 55
        op8(8'd200, 8'd55, rd, rbo, lat, bcnt, early);
        chk("d200_55_diff", 32'(rd), 145);
        chk("d200_55_borrow", 32'(rbo), 0);
        chk("d200_55_latency", 32'(lat), 9);
        chk("d200_55_busy_cycles", 32'(bcnt), 8);
        @(negedge clk);
        chk("done_one_cycle", 32'(done8), 0);
        chk("hold_after_done", 32'(diff8), 145);

        // 5 - 10; previous result must hold during SHIFT
        op8(8'd5, 8'd10, rd, rbo, lat, bcnt, early);
        chk("hold_during_shift", 32'(early), 145);
        chk("d5_10_diff", 32'(rd), 251);
        chk("d5_10_borrow", 32'(rbo), 1);

        op8(8'd0, 8'd0, rd, rbo, lat, bcnt, early);
        chk("d0_0_diff", 32'(rd), 0);
        chk("d0_0_borrow", 32'(rbo), 0);
        op8(8'd255, 8'd255, rd, rbo, lat, bcnt, early);
        chk("d255_255_diff", 32'(rd), 0);
        chk("d255_255_borrow", 32'(rbo), 0);

        // start pulsed 3 cycles into SHIFT is ignored
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd30;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 30) begin @(negedge clk); cyc++; end
        chk("ignore_start_done_seen", 32'(done8), 1);
        chk("ignore_start_diff", 32'(diff8), 70);
        chk("ignore_start_borrow", 32'(bo8), 0);
        @(negedge clk);
        chk("ignore_start_no_second_op", 32'(busy8), 0);

        // reset 4 cycles into SHIFT aborts
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd77; b8 = 8'd11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_diff", 32'(diff8), 0);
        chk("abort_borrow", 32'(bo8), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (done8) seen++; end
        chk("abort_no_done", 32'(seen), 0);
        op8(8'd9, 8'd3, rd, rbo, lat, bcnt, early);
        chk("after_abort_diff", 32'(rd), 6);
        chk("after_abort_borrow", 32'(rbo), 0);

        // random ops vs modular arithmetic
        for (int i = 0; i < 20; i++) begin
            ea = 8'($urandom); eb = 8'($urandom);
            op8(ea, eb, rd, rbo, lat, bcnt, early);
            chk("rand_diff", 32'(rd), 32'(8'(ea - eb)));
            chk("rand_borrow", 32'(rbo), 32'(ea < eb));
            chk("rand_latency", 32'(lat), 9);
        end

        // start held high: one result per 9 cycles, operands from the accepting edge
        @(negedge clk);
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        qa.push_back(a8); qb.push_back(b8);
        cyc = 0; ndone = 0; last_done = 0;
        while (ndone < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            a8 = 8'($urandom); b8 = 8'($urandom);
            if (done8) begin
                ea = qa.pop_front(); eb = qb.pop_front();
                chk("b2b_diff", 32'(diff8), 32'(8'(ea - eb)));
                chk("b2b_borrow", 32'(bo8), 32'(ea < eb));
                if (ndone > 0) chk("b2b_period", 32'(cyc - last_done), 9);
                last_done = cyc;
                ndone++;
                qa.push_back(a8); qb.push_back(b8);
            end
        end
        chk("b2b_results", 32'(ndone), 6);
        start8 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // WIDTH=4 exhaustive
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ta4 = 5'(i); tb4 = 5'(j);
                @(negedge clk);
                start4 = 1'b1; a4 = ta4[3:0]; b4 = tb4[3:0];
                @(negedge clk);
                start4 = 1'b0;
                cyc = 0;
                while (!done4 && cyc < 20) begin @(negedge clk); cyc++; end
                chk("w4_done", 32'(done4), 1);
                chk("w4_diff", 32'(diff4), 32'((i - j) & 15));
                chk("w4_borrow", 32'(bo4), 32'(i < j));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
